// File: rtl/keypad_code_sender_pkg.sv
// ---------------------------------------------------------------------------
// keypad_code_sender_pkg
//   Shared definitions for the keypad PIN producer.
//   - kpd_state_e     : FSM state encoding (IDLE, COLLECT, SEND, GAP)
//   - KPD_NUM_DIGITS  : digits per PIN
//   - KPD_DIGIT_W     : bits per BCD digit
//   - KPD_CODE_W      : width of the packed PIN
//   - kpd_digit_legal : true for BCD 0..9
// ---------------------------------------------------------------------------
package keypad_code_sender_pkg;

    localparam int KPD_NUM_DIGITS = 4;
    localparam int KPD_DIGIT_W    = 4;
    localparam int KPD_CODE_W     = KPD_NUM_DIGITS * KPD_DIGIT_W;

    typedef enum logic [1:0] {
        KPD_IDLE    = 2'd0,
        KPD_COLLECT = 2'd1,
        KPD_SEND    = 2'd2,
        KPD_GAP     = 2'd3
    } kpd_state_e;

    function automatic logic kpd_digit_legal(input logic [KPD_DIGIT_W-1:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_code_sender_kpd_cycle_timer.sv
// ---------------------------------------------------------------------------
// kpd_cycle_timer
//   Loadable down-counter shared by the SEND hold, the GAP hold and the
//   optional idle timeout. It counts down to zero and then rests there.
//   Ports:
//     clk      in   clock
//     rst      in   synchronous active-high reset (count -> 0)
//     load     in   load load_val this cycle
//     load_val in   CNT_W value to load
//     clear    in   force count to 0 (wins over load)
//     done     out  count is zero
// ---------------------------------------------------------------------------
module kpd_cycle_timer
    import keypad_code_sender_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/keypad_code_sender.sv
// ---------------------------------------------------------------------------
// keypad_code_sender
//   Keypad-side producer of the PIN handshake. Collects four BCD digits
//   (first digit ends up in code[15:12]), presents the packed code with
//   code_ack held high for ACK_HOLD cycles, then holds code_ack low (busy)
//   for GAP_CYCLES so the consumer always sees the ack release.
//
//   Optional feature: define KPD_TIMEOUT_EN to discard a partial entry after
//   TIMEOUT_CYCLES cycles in COLLECT without any key strobe.
//
//   Ports:
//     clk            in   clock, posedge
//     rst            in   synchronous active-high reset
//     enable         in   vehicle present; low aborts and clears the entry
//     key_valid      in   strobe: key_data holds a digit
//     key_data [3:0] in   BCD digit (10..15 rejected)
//     key_enter      in   strobe: submit entry
//     key_clear      in   strobe: discard partial entry
//     code [15:0]    out  packed PIN, held until the next submission
//     code_ack       out  code valid level, ACK_HOLD cycles
//     digits_entered out  digits buffered, 0..4
//     entry_err      out  one-cycle pulse on rejected key / short submit
//     busy           out  high in SEND and GAP
// ---------------------------------------------------------------------------
module keypad_code_sender
    import keypad_code_sender_pkg::*;
#(
    parameter int ACK_HOLD       = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [3:0]  key_data,
    input  logic        key_enter,
    input  logic        key_clear,
    output logic [15:0] code,
    output logic        code_ack,
    output logic [2:0]  digits_entered,
    output logic        entry_err,
    output logic        busy
);

    // The timer counts down to zero inclusive, so loading N-1 gives N cycles.
    localparam logic [CNT_W-1:0] ACK_LOAD     = CNT_W'(ACK_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       FULL_DIGITS  = 3'(KPD_NUM_DIGITS);

    kpd_state_e            state_q, state_d;
    logic [KPD_CODE_W-1:0] buf_q, buf_d;
    logic [KPD_CODE_W-1:0] code_q, code_d;
    logic [2:0]            digits_q, digits_d;
    logic                  code_ack_q, code_ack_d;
    logic                  busy_q, busy_d;
    logic                  entry_err_q, entry_err_d;

    logic                  timer_load;
    logic [CNT_W-1:0]      timer_load_val;
    logic                  timer_clear;
    logic                  timer_done;

    logic                  digit_ok;
    logic                  buf_full;

    assign digit_ok = kpd_digit_legal(key_data);
    assign buf_full = (digits_q == FULL_DIGITS);

    kpd_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .clear    (timer_clear),
        .done     (timer_done)
    );

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        code_d         = code_q;
        digits_d       = digits_q;
        code_ack_d     = code_ack_q;
        busy_d         = busy_q;
        entry_err_d    = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_clear    = 1'b0;

        if (!enable) begin
            // Vehicle left: abort everything except the last presented code.
            state_d     = KPD_IDLE;
            code_ack_d  = 1'b0;
            busy_d      = 1'b0;
            buf_d       = '0;
            digits_d    = '0;
            timer_clear = 1'b1;
        end else begin
            unique case (state_q)
                KPD_IDLE: begin
                    // clear/enter outrank a same-cycle digit, and do nothing here.
                    if (!key_clear && !key_enter && key_valid) begin
                        if (digit_ok) begin
                            buf_d          = {{(KPD_CODE_W-KPD_DIGIT_W){1'b0}}, key_data};
                            digits_d       = 3'd1;
                            state_d        = KPD_COLLECT;
                            timer_load     = 1'b1;
                            timer_load_val = TIMEOUT_LOAD;
                        end else begin
                            entry_err_d = 1'b1;
                        end
                    end
                end

                KPD_COLLECT: begin
                    if (key_clear) begin
                        buf_d    = '0;
                        digits_d = '0;
                        state_d  = KPD_IDLE;
                    end else if (key_enter) begin
                        if (buf_full) begin
                            code_d         = buf_q;
                            code_ack_d     = 1'b1;
                            busy_d         = 1'b1;
                            buf_d          = '0;
                            digits_d       = '0;
                            state_d        = KPD_SEND;
                            timer_load     = 1'b1;
                            timer_load_val = ACK_LOAD;
                        end else begin
                            entry_err_d = 1'b1;
                            buf_d       = '0;
                            digits_d    = '0;
                            state_d     = KPD_IDLE;
                        end
                    end else if (key_valid) begin
                        // Any digit strobe, accepted or not, restarts the idle window.
                        timer_load     = 1'b1;
                        timer_load_val = TIMEOUT_LOAD;
                        if (digit_ok && !buf_full) begin
                            buf_d    = {buf_q[KPD_CODE_W-KPD_DIGIT_W-1:0], key_data};
                            digits_d = digits_q + 3'd1;
                        end else begin
                            entry_err_d = 1'b1;
                        end
                    end
`ifdef KPD_TIMEOUT_EN
                    else if (timer_done) begin
                        buf_d       = '0;
                        digits_d    = '0;
                        entry_err_d = 1'b1;
                        state_d     = KPD_IDLE;
                    end
`endif
                end

                KPD_SEND: begin
                    if (timer_done) begin
                        code_ack_d     = 1'b0;
                        state_d        = KPD_GAP;
                        timer_load     = 1'b1;
                        timer_load_val = GAP_LOAD;
                    end
                end

                KPD_GAP: begin
                    if (timer_done) begin
                        busy_d  = 1'b0;
                        state_d = KPD_IDLE;
                    end
                end

                default: begin
                    state_d = KPD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= KPD_IDLE;
            buf_q       <= '0;
            code_q      <= '0;
            digits_q    <= '0;
            code_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            entry_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            code_q      <= code_d;
            digits_q    <= digits_d;
            code_ack_q  <= code_ack_d;
            busy_q      <= busy_d;
            entry_err_q <= entry_err_d;
        end
    end

    assign code           = code_q;
    assign code_ack       = code_ack_q;
    assign digits_entered = digits_q;
    assign entry_err      = entry_err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_keypad_code_sender.sv
// ---------------------------------------------------------------------------
// tb_keypad_code_sender
//   Directed self-checking bench for keypad_code_sender with ACK_HOLD=4,
//   GAP_CYCLES=2, TIMEOUT_CYCLES=8. Inputs change on the falling edge and
//   outputs are checked on the falling edge after the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_keypad_code_sender;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_data;
    logic        key_enter;
    logic        key_clear;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digits_entered;
    logic        entry_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    keypad_code_sender #(
        .ACK_HOLD       (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .key_valid      (key_valid),
        .key_data       (key_data),
        .key_enter      (key_enter),
        .key_clear      (key_clear),
        .code           (code),
        .code_ack       (code_ack),
        .digits_entered (digits_entered),
        .entry_err      (entry_err),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Called on a falling edge: drives one strobe cycle, returns on the next falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d,
                                 input logic e, input logic c);
        key_valid = v;
        key_data  = d;
        key_enter = e;
        key_clear = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_data  = 4'h0;
        key_enter = 1'b0;
        key_clear = 1'b0;
    endtask

    task automatic pressKey(input logic [3:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pressEnter();
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] pin);
        for (int i = 3; i >= 0; i--) begin
            pressKey(pin[i*4 +: 4]);
        end
        pressEnter();
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        key_valid = 1'b0;
        key_data  = 4'h0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        @(negedge clk);
        doReset();

        $display("[TB] reset state");
        checkOutput("rst_code",   code, 16'h0000);
        checkOutput("rst_ack",    16'(code_ack), 16'd0);
        checkOutput("rst_digits", 16'(digits_entered), 16'd0);
        checkOutput("rst_err",    16'(entry_err), 16'd0);
        checkOutput("rst_busy",   16'(busy), 16'd0);

        $display("[TB] full submission 2468");
        enterCode(16'h2468);
        checkOutput("send_code",   code, 16'h2468);
        checkOutput("send_ack1",   16'(code_ack), 16'd1);
        checkOutput("send_busy",   16'(busy), 16'd1);
        checkOutput("send_digits", 16'(digits_entered), 16'd0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("send_ack%0d", i), 16'(code_ack), 16'd1);
        end
        @(negedge clk);
        checkOutput("gap1_ack",  16'(code_ack), 16'd0);
        checkOutput("gap1_busy", 16'(busy), 16'd1);
        @(negedge clk);
        checkOutput("gap2_ack",  16'(code_ack), 16'd0);
        checkOutput("gap2_busy", 16'(busy), 16'd1);
        @(negedge clk);
        checkOutput("idle_busy", 16'(busy), 16'd0);
        checkOutput("idle_code", code, 16'h2468);

        $display("[TB] short submission");
        doReset();
        pressKey(4'd1);
        pressKey(4'd2);
        checkOutput("short_digits2", 16'(digits_entered), 16'd2);
        pressEnter();
        checkOutput("short_err",    16'(entry_err), 16'd1);
        checkOutput("short_ack",    16'(code_ack), 16'd0);
        checkOutput("short_digits", 16'(digits_entered), 16'd0);
        @(negedge clk);
        checkOutput("short_err_off", 16'(entry_err), 16'd0);
        checkOutput("short_ack2",    16'(code_ack), 16'd0);

        $display("[TB] fifth digit rejected");
        pressKey(4'd1);
        pressKey(4'd2);
        pressKey(4'd3);
        pressKey(4'd4);
        checkOutput("five_err_before", 16'(entry_err), 16'd0);
        pressKey(4'd5);
        checkOutput("five_err",    16'(entry_err), 16'd1);
        checkOutput("five_digits", 16'(digits_entered), 16'd4);
        pressEnter();
        checkOutput("five_code", code, 16'h1234);
        checkOutput("five_ack",  16'(code_ack), 16'd1);
        waitCycles(6);
        checkOutput("five_idle", 16'(busy), 16'd0);

        $display("[TB] illegal digit and clear priority");
        pressKey(4'hC);
        checkOutput("idle_bad_err",    16'(entry_err), 16'd1);
        checkOutput("idle_bad_digits", 16'(digits_entered), 16'd0);
        pressKey(4'd3);
        pressKey(4'hA);
        checkOutput("coll_bad_err",    16'(entry_err), 16'd1);
        checkOutput("coll_bad_digits", 16'(digits_entered), 16'd1);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
        checkOutput("clr_digits", 16'(digits_entered), 16'd0);
        checkOutput("clr_err",    16'(entry_err), 16'd0);

        $display("[TB] enable drop during send, keys ignored");
        enterCode(16'h9075);
        checkOutput("abort_code", code, 16'h9075);
        pressKey(4'd5);
        checkOutput("abort_key_digits", 16'(digits_entered), 16'd0);
        checkOutput("abort_key_err",    16'(entry_err), 16'd0);
        checkOutput("abort_ack_c2",     16'(code_ack), 16'd1);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        checkOutput("abort_ack",  16'(code_ack), 16'd0);
        checkOutput("abort_busy", 16'(busy), 16'd0);
        checkOutput("abort_hold", code, 16'h9075);
        pressKey(4'd6);
        checkOutput("abort_idle_key", 16'(digits_entered), 16'd1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        enterCode(16'h1111);
        waitCycles(4);
        checkOutput("gap_enter_ack", 16'(code_ack), 16'd0);
        pressKey(4'd7);
        checkOutput("gap_key_digits", 16'(digits_entered), 16'd0);
        checkOutput("gap_key_busy",   16'(busy), 16'd1);
        @(negedge clk);
        checkOutput("gap_done_busy", 16'(busy), 16'd0);
        checkOutput("gap_done_digits", 16'(digits_entered), 16'd0);
        pressKey(4'd9);
        checkOutput("post_gap_key", 16'(digits_entered), 16'd1);

        $display("[TB] reset mid-send");
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        enterCode(16'h4321);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_send_ack",  16'(code_ack), 16'd0);
        checkOutput("rst_send_code", code, 16'h0000);

        $display("[TB] idle timeout window");
        pressKey(4'd7);
        checkOutput("to_digits1", 16'(digits_entered), 16'd1);
        waitCycles(7);
        checkOutput("to_before_digits", 16'(digits_entered), 16'd1);
        checkOutput("to_before_err",    16'(entry_err), 16'd0);
        waitCycles(1);
`ifdef KPD_TIMEOUT_EN
        checkOutput("to_err",    16'(entry_err), 16'd1);
        checkOutput("to_digits", 16'(digits_entered), 16'd0);
`else
        checkOutput("to_err",    16'(entry_err), 16'd0);
        checkOutput("to_digits", 16'(digits_entered), 16'd1);
        waitCycles(20);
        checkOutput("to_digits_long", 16'(digits_entered), 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
